// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg: shared types and constants for the pipeline hazard sequencer.
//   hz_state_t  : sequencer state (RUN, MEM_WAIT, ERR)
//   pipe_ctrl_t : per-pipe-register control pair {en, flush}
//   PIPE_*      : canned control pairs used by the sequencer
// Optional feature macro used by the files that import this package:
//   HAZARD_PERF_EN (performance counters).
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } pipe_ctrl_t;

    // Normal advance.
    localparam pipe_ctrl_t PIPE_RUN    = '{en: 1'b1, flush: 1'b0};
    // Hold contents (frozen pipeline).
    localparam pipe_ctrl_t PIPE_HOLD   = '{en: 1'b0, flush: 1'b0};
    // Load a bubble on the next edge.
    localparam pipe_ctrl_t PIPE_BUBBLE = '{en: 1'b1, flush: 1'b1};
    // Value presented while reset is asserted.
    localparam pipe_ctrl_t PIPE_RESET  = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if: bundle between the datapath and the hazard sequencer.
//   master modport : datapath side (drives hazard inputs, receives controls)
//   slave modport  : sequencer side
// Inputs : id_rs1/id_rs2/id_use_rs1/id_use_rs2, ex_mem_read, ex_rd,
//          mem_branch_taken, dmem_req, dmem_ready
// Outputs: pc_en, pc_sel_branch, *_en, *_flush, mem_wait, mem_timeout_err,
//          stall_cycles/flush_events (only when HAZARD_PERF_EN is defined)
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W = 32
`endif
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_branch_taken;
    logic                  dmem_req;
    logic                  dmem_ready;

    logic pc_en;
    logic pc_sel_branch;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wait;
    logic mem_timeout_err;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               mem_branch_taken, dmem_req, dmem_ready,
        input  pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wait, mem_timeout_err
`ifdef HAZARD_PERF_EN
               , stall_cycles, flush_events
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               mem_branch_taken, dmem_req, dmem_ready,
        output pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wait, mem_timeout_err
`ifdef HAZARD_PERF_EN
               , stall_cycles, flush_events
`endif
    );

endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect: combinational load-use hazard detector.
//   Raises stall_req when the instruction in EX is a load writing a non-zero
//   register that the instruction in ID actually reads (rs1 or rs2).
// Ports: id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd (in),
//        stall_req (out)
// ---------------------------------------------------------------------------
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  stall_req
);

    logic [REG_ADDR_W-1:0] src_reg [2];
    logic [1:0]            src_use;
    logic [1:0]            src_hit;

    assign src_reg[0] = id_rs1;
    assign src_reg[1] = id_rs2;
    assign src_use    = {id_use_rs2, id_use_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_reg[gi] == ex_rd);
        end
    endgenerate

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign stall_req = ex_mem_read && (ex_rd != '0) && (|src_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl: central pipeline sequencer for the 5-stage RV32 core.
//   Resolves memory freezes (with timeout), taken-branch flushes and
//   load-use stalls, in that priority order.
// Ports: clk, rst (asynchronous, active high), bus (hazard_stall_ctrl_if.slave)
// Optional feature: define HAZARD_PERF_EN to add the stall_cycles and
//   flush_events performance counters (CNT_W bits, wrapping).
// Controls are combinational from the registered state and current inputs.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEFAULT,
    parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave bus
);

    // Must hold the value MEM_TIMEOUT reached on the cycle that enters ERR.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic       load_use;
    logic       freeze;
    logic       run_eval;
    logic       err_c;
    logic       pc_en_c;
    logic       pc_sel_c;
    logic       mem_wb_en_c;
    logic       mem_wait_c;
    pipe_ctrl_t if_id_c, id_ex_c, ex_mem_c;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_use_rs1  (bus.id_use_rs1),
        .id_use_rs2  (bus.id_use_rs2),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .stall_req   (load_use)
    );

    // Next-state logic; run_eval marks cycles handled by the RUN priority
    // chain (including the MEM_WAIT release cycle).
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        run_eval   = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.dmem_req && !bus.dmem_ready) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!bus.dmem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ERR;
                    end
                end else begin
                    run_eval   = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                freeze = 1'b1;
                err_c  = 1'b1;
            end
            default: begin
                freeze     = 1'b1;
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Output logic: freeze > branch flush > load-use stall > default.
    always_comb begin
        pc_en_c     = 1'b1;
        pc_sel_c    = 1'b0;
        mem_wb_en_c = 1'b1;
        mem_wait_c  = 1'b0;
        if_id_c     = PIPE_RUN;
        id_ex_c     = PIPE_RUN;
        ex_mem_c    = PIPE_RUN;
        if (freeze) begin
            pc_en_c     = 1'b0;
            mem_wb_en_c = 1'b0;
            mem_wait_c  = 1'b1;
            if_id_c     = PIPE_HOLD;
            id_ex_c     = PIPE_HOLD;
            ex_mem_c    = PIPE_HOLD;
        end else if (run_eval && bus.mem_branch_taken) begin
            // The branch squashes a co-incident load-use victim as well.
            pc_sel_c = 1'b1;
            if_id_c  = PIPE_BUBBLE;
            id_ex_c  = PIPE_BUBBLE;
            ex_mem_c = PIPE_BUBBLE;
        end else if (run_eval && load_use) begin
            pc_en_c = 1'b0;
            if_id_c = PIPE_HOLD;
            id_ex_c = PIPE_BUBBLE;
        end
        if (rst) begin
            pc_en_c     = 1'b0;
            pc_sel_c    = 1'b0;
            mem_wb_en_c = 1'b0;
            mem_wait_c  = 1'b0;
            if_id_c     = PIPE_RESET;
            id_ex_c     = PIPE_RESET;
            ex_mem_c    = PIPE_RESET;
        end
    end

    assign bus.pc_en           = pc_en_c;
    assign bus.pc_sel_branch   = pc_sel_c;
    assign bus.if_id_en        = if_id_c.en;
    assign bus.id_ex_en        = id_ex_c.en;
    assign bus.ex_mem_en       = ex_mem_c.en;
    assign bus.mem_wb_en       = mem_wb_en_c;
    assign bus.if_id_flush     = if_id_c.flush;
    assign bus.id_ex_flush     = id_ex_c.flush;
    assign bus.ex_mem_flush    = ex_mem_c.flush;
    assign bus.mem_wait        = mem_wait_c;
    assign bus.mem_timeout_err = err_c && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(!pc_en_c);
        flush_events_d = flush_events_q + CNT_W'(pc_sel_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl: directed then randomized checks of hazard_stall_ctrl
// against a rule-level reference model (frozen-cycle count, error flag,
// counter totals). Optional HAZARD_PERF_EN also checks the perf counters.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst;

`ifdef HAZARD_PERF_EN
    hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) hif ();
    hazard_stall_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(hif.slave)
    );
`else
    hazard_stall_ctrl_if #(.REG_ADDR_W(5)) hif ();
    hazard_stall_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .bus(hif.slave)
    );
`endif

    always #5 clk = ~clk;

    int          checks  = 0;
    int          errors  = 0;
    int          step_no = 0;
    int          m_frozen_run = 0;   // consecutive frozen cycles so far
    bit          m_err = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    task automatic set_in(input bit req, input bit rdy, input bit br, input bit mr,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input bit u1, input bit u2);
        hif.dmem_req         = req;
        hif.dmem_ready       = rdy;
        hif.mem_branch_taken = br;
        hif.ex_mem_read      = mr;
        hif.ex_rd            = rd;
        hif.id_rs1           = rs1;
        hif.id_rs2           = rs2;
        hif.id_use_rs1       = u1;
        hif.id_use_rs2       = u2;
    endtask

    task automatic idle();
        set_in(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Expected {pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //           if_id_flush, id_ex_flush, ex_mem_flush, mem_wait, mem_timeout_err}
    function automatic logic [10:0] expect_out(output bit frozen);
        bit lu;
        frozen = 1'b0;
        if (rst) return 11'b0_0_0000_111_0_0;
        if (m_err) begin
            frozen = 1'b1;
            return 11'b0_0_0000_000_1_1;
        end
        // Waiting on memory: an outstanding access keeps the pipe frozen until ready.
        frozen = !hif.dmem_ready && (m_frozen_run > 0 || hif.dmem_req);
        if (frozen) return 11'b0_0_0000_000_1_0;
        lu = hif.ex_mem_read && (hif.ex_rd != 0) &&
             ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) ||
              (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
        if (hif.mem_branch_taken) return 11'b1_1_1111_111_0_0;
        if (lu) return 11'b0_0_0111_010_0_0;
        return 11'b1_0_1111_000_0_0;
    endfunction

    task automatic check_and_tick(input string tag);
        logic [10:0] e;
        logic [10:0] o;
        bit          fr;
        #1;
        e = expect_out(fr);
        o = {hif.pc_en, hif.pc_sel_branch, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en,
             hif.mem_wb_en, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush,
             hif.mem_wait, hif.mem_timeout_err};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: outputs=%b expected=%b", tag, o, e);
        end
`ifdef HAZARD_PERF_EN
        begin
            logic [31:0] es;
            logic [31:0] ef;
            es = rst ? 32'd0 : m_stall;
            ef = rst ? 32'd0 : m_flush;
            checks++;
            assert (hif.stall_cycles === es) else begin
                errors++;
                $error("FAIL %s_stall_cycles: got=%0d expected=%0d", tag, hif.stall_cycles, es);
            end
            checks++;
            assert (hif.flush_events === ef) else begin
                errors++;
                $error("FAIL %s_flush_events: got=%0d expected=%0d", tag, hif.flush_events, ef);
            end
        end
`endif
        $display("step %0d %s rst=%0b out=%b", step_no, tag, rst, o);
        step_no++;
        @(posedge clk);
        if (rst) begin
            m_frozen_run = 0;
            m_err        = 1'b0;
            m_stall      = '0;
            m_flush      = '0;
        end else begin
            if (!e[10]) m_stall = m_stall + 1;
            if (e[9])   m_flush = m_flush + 1;
            if (!m_err) begin
                if (fr) begin
                    m_frozen_run++;
                    if (m_frozen_run >= T) m_err = 1'b1;
                end else begin
                    m_frozen_run = 0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk); check_and_tick("reset");
        @(negedge clk); rst = 1'b0; idle(); check_and_tick("idle");

        // Load-use on rs1, then release
        @(negedge clk); set_in(0, 1, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0); check_and_tick("load_use_rs1");
        @(negedge clk); idle(); check_and_tick("load_use_release");
        @(negedge clk); set_in(0, 1, 0, 1, 5'd0, 5'd0, 5'd1, 1, 0); check_and_tick("load_use_x0");
        @(negedge clk); set_in(0, 1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 1); check_and_tick("load_use_rs2");
        @(negedge clk); set_in(0, 1, 0, 1, 5'd7, 5'd7, 5'd7, 0, 0); check_and_tick("load_use_unread");
        @(negedge clk); set_in(0, 1, 0, 0, 5'd7, 5'd7, 5'd7, 1, 1); check_and_tick("no_load");

        // Taken branch
        @(negedge clk); set_in(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0); check_and_tick("branch");
        @(negedge clk); idle(); check_and_tick("branch_after");

        // Three-cycle memory wait, release on the fourth
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); check_and_tick("mem_wait");
        end
        @(negedge clk); set_in(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); check_and_tick("mem_release");
        @(negedge clk); set_in(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); check_and_tick("mem_fast");

        // Freeze beats branch and load-use; branch wins on release
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_in(1, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0); check_and_tick("prio_freeze");
        end
        @(negedge clk); set_in(1, 1, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0); check_and_tick("prio_release");
        @(negedge clk); idle(); check_and_tick("prio_after");

        // Timeout into ERR, sticky even after ready rises
        for (int i = 0; i < T; i++) begin
            @(negedge clk); set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); check_and_tick("timeout_wait");
        end
        @(negedge clk); check_and_tick("err_state");
        @(negedge clk); set_in(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0); check_and_tick("err_sticky");

        // Asynchronous reset out of ERR
        @(negedge clk); #2 rst = 1'b1; check_and_tick("rst_from_err");
        @(negedge clk); rst = 1'b0; idle(); check_and_tick("post_rst_err");

        // Asynchronous reset in the middle of a memory wait
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); check_and_tick("pre_rst_wait");
        end
        @(negedge clk); #2 rst = 1'b1; check_and_tick("rst_mid_wait");
        @(negedge clk); rst = 1'b0; idle(); check_and_tick("post_rst_wait");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) < 2);
            set_in($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 65,
                   $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 50,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            check_and_tick("rand");
        end

        @(negedge clk); rst = 1'b0; idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
- Drives the PC enable and redirect select, plus per-pipe-register enable/flush controls.
- Resolves three hazards:
  - load-use hazards (detected in ID against EX);
  - taken branches (resolved at the EX/MEM register output);
  - multi-cycle data-memory accesses (ready handshake with timeout).
- Complements the existing forwarding unit; it does not modify datapath values.

Parameters:
REG_ADDR_W, 5, register index width
MEM_TIMEOUT, 16, max consecutive wait cycles before error (≥2)
CNT_W, 32, perf counter width (only with HAZARD_PERF_EN)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_rs1, id_rs2  in  REG_ADDR_W  source regs of instruction in ID
id_use_rs1, id_use_rs2  in  1  instruction in ID actually reads rs1/rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_ADDR_W  destination of instruction in EX
mem_branch_taken  in  1  branch in MEM stage taken (BranchControl output)
dmem_req  in  1  MEM stage issuing read or write
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register load enable
pc_sel_branch  out  1  PC mux selects branch target
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipe register enables (0 = hold)
if_id_flush, id_ex_flush, ex_mem_flush  out  1  load bubble (all fields/controls zero)
mem_wait  out  1  pipeline frozen on memory
mem_timeout_err  out  1  sticky timeout error
stall_cycles, flush_events  out  CNT_W  perf counters (HAZARD_PERF_EN only)

Behaviour:
- Output timing:
  - Control outputs are combinational from the registered state and the current inputs.
  - State, wait counter, error flag and perf counters are registered on posedge clk, with async clear on rst.
- While rst=1:
  - pc_en=0, all *_en=0, all *_flush=1, pc_sel_branch=0, mem_wait=0, mem_timeout_err=0.
  - state=RUN, wait_cnt=0, counters=0.
- Default (RUN, no hazard): all enables 1, all flushes 0, pc_sel_branch=0.
- States are RUN, MEM_WAIT and ERR.
- Priority in RUN: memory freeze > branch flush > load-use stall.
- Memory freeze:
  - Trigger: in RUN, dmem_req=1 and dmem_ready=0.
  - Outputs that cycle: all enables 0, no flushes, mem_wait=1.
  - Next state MEM_WAIT, wait_cnt=1.
- MEM_WAIT:
  - While dmem_ready=0: freeze as above and wait_cnt+1.
  - When wait_cnt reaches MEM_TIMEOUT-1 with dmem_ready still 0, next state is ERR.
  - When dmem_ready=1, that same cycle is evaluated exactly as RUN with the freeze term removed; next state RUN, wait_cnt=0.
  - An access that completes on its first cycle (ready with req) costs zero stall cycles.
- ERR: permanent freeze, mem_wait=1, mem_timeout_err=1; only rst exits.
- Branch flush (mem_branch_taken=1, not frozen):
  - pc_sel_branch=1, pc_en=1.
  - if_id_flush=id_ex_flush=ex_mem_flush=1.
  - Exactly 3 bubbles; a branch pending during a freeze is applied on the release cycle.
- Load-use stall:
  - Condition: ex_mem_read=1, ex_rd≠0, and (id_use_rs1 with ex_rd==id_rs1, or id_use_rs2 with ex_rd==id_rs2).
  - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1.
  - Exactly one bubble; WB→EX forwarding covers the following cycle.
- A simultaneous branch and load-use resolves as a branch; the stalled instruction is flushed anyway.
- Register x0 never causes a stall.
- rst mid-freeze or in ERR returns to RUN immediately (asynchronous).

Optional Feature:
- Macro HAZARD_PERF_EN. When defined:
  - stall_cycles increments each cycle pc_en=0 outside reset.
  - flush_events increments once per cycle with pc_sel_branch=1.
  - Both counters wrap modulo 2^CNT_W.
- When undefined: counters and ports are absent; no other behaviour changes.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum hz_state_t {RUN, MEM_WAIT, ERR};
  - REG_ADDR_W default;
  - a pipe_ctrl_t struct {en, flush}.
- One natural sub-module: load_use_detect, purely combinational, producing the stall request.
- The FSM and counters stay in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_en=0, if_id_en=0, id_ex_flush=1 for 1 cycle. The same stimulus with ex_rd=0 → no stall.
- Branch: mem_branch_taken=1 for 1 cycle → pc_sel_branch=1 and the three flushes =1 that cycle; with HAZARD_PERF_EN, flush_events goes 0→1.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles then high → mem_wait=1 and all enables 0 for 3 cycles, release on the 4th; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_req=1, dmem_ready held 0 → state ERR after 4 frozen cycles; mem_timeout_err=1 and stays 1 even when dmem_ready later rises.
- Priority: dmem_req=1/dmem_ready=0 plus mem_branch_taken=1 and a load-use → freeze only. When ready rises, the branch flush is applied and the load-use stall is suppressed.
- Reset mid-operation: assert rst during MEM_WAIT (asynchronous, mid-cycle) → outputs take reset values immediately. Deassert → RUN defaults on the next clock, with counters 0.
